alu_pipe: RTL and testbench
===========================

// Module: alu_pipe
// PURPOSE
//  Parametrised, pipelined successor to the Hack combinational ALU. Same zx/nx/zy/ny/f/no op encoding,
//  generalised to WIDTH bits. Two register stages with valid/ready flow control on both sides.
//  Sits between decode and writeback in the pipelined Hack CPU; drains through a backpressured result port.
// PARAMETERS
//  WIDTH    16  operand/result width in bits (>=2)
// PORTS
//  clk        in   1      rising-edge clock
//  rst_n      in   1      synchronous active-low reset
//  in_valid   in   1      x/y/ctrl valid this cycle
//  in_ready   out  1      block accepts operands this cycle
//  x          in   WIDTH  operand x
//  y          in   WIDTH  operand y
//  ctrl       in   6      {zx,nx,zy,ny,f,no}
//  out_valid  out  1      result valid
//  out_ready  in   1      consumer accepts result
//  out        out  WIDTH  result
//  zr         out  1      out == 0
//  ng         out  1      out[WIDTH-1]
//  carry      out  1      (ALU_PIPE_FLAGS_EN only) adder carry-out
//  ovf        out  1      (ALU_PIPE_FLAGS_EN only) signed add overflow
// BEHAVIOUR
//  - Accept on in_valid&&in_ready; deliver on out_valid&&out_ready. No other transfer.
//  - S1 registers x2=nx?~(zx?0:x):(zx?0:x), y2 likewise, plus {f,no}. S2 registers
//    fout=f?x2+y2:x2&y2 (mod 2^WIDTH), res=no?~fout:fout, zr=~|res, ng=res[WIDTH-1].
//  - Latency: 2 cycles accept->out_valid with out_ready held high; throughput 1/cycle.
//  - Stage advance: S2 loads when !s2_vld || out_ready; S1 loads when !s1_vld || S2 loads.
//    in_ready = !s1_vld || !s2_vld || out_ready (combinational from out_ready, no in_valid path).
//  - Stall: while out_valid && !out_ready, out/zr/ng/carry/ovf stay stable; no beat lost or duplicated.
//  - Full (both stages valid, out_ready=0): in_ready=0. Simultaneous accept+deliver when full is allowed.
//  - Reset (rst_n=0 at clk edge), incl. mid-operation: s1_vld=s2_vld=0, out=0, zr=0, ng=0,
//    carry=0, ovf=0; in-flight beats discarded. in_ready=1 from first cycle after reset.
//  - Data registers load only on stage advance; flags always reflect the registered res.
// CONFIGURATION
//  ALU_PIPE_FLAGS_EN defined: carry/ovf ports exist. When f=1: carry=carry-out of x2+y2,
//    ovf=(x2[W-1]==y2[W-1])&&(sum[W-1]!=x2[W-1]), both before no-inversion; when f=0 both 0.
//    Registered in S2 with res, same stall/reset rules.
//  Not defined: ports and logic absent; all other behaviour identical.
// STRUCTURE
//  alu_pkg: alu_ctrl_t packed struct {zx,nx,zy,ny,f,no}; op constants ALU_OP_ZERO=6'b101010,
//    ALU_OP_ONE=6'b111111, ALU_OP_NEG1=6'b111010, ALU_OP_X=6'b001100, ALU_OP_Y=6'b110000,
//    ALU_OP_NOTX=6'b001101, ALU_OP_XPLUSY=6'b000010, ALU_OP_XMINUSY=6'b010011, ALU_OP_XANDY=6'b000000,
//    ALU_OP_XORY=6'b010101.
//  Sub-module: alu_pipe_slice (parametrised valid/ready register slice), instanced once per stage.
// TESTING
//  1. W=16, out_ready=1: x=5,y=3,ALU_OP_XPLUSY -> out=8,zr=0,ng=0 exactly 2 cycles after accept.
//  2. x=3,y=5,ALU_OP_XMINUSY -> out=16'hFFFE,ng=1; x=7,y=7 same op -> out=0,zr=1.
//  3. Back-to-back 10 ops, out_ready=0 for 4 cycles mid-stream -> in_ready drops after 2 held beats,
//     out stable during stall, all 10 results in order, none lost/duplicated.
//  4. Full pipe, rst_n=0 one cycle -> out_valid=0, out=0, zr=0, ng=0 next cycle; in_ready=1.
//  5. FLAGS_EN: x=16'h7FFF,y=1,XPLUSY -> out=16'h8000,ovf=1,carry=0; x=16'hFFFF,y=1 -> out=0,carry=1,zr=1.
//  6. W=8: ALU_OP_NEG1 -> out=8'hFF,ng=1; ALU_OP_ONE -> out=8'h01; ALU_OP_XORY x=8'hA0,y=8'h0A -> 8'hAA.

Source files
------------

// File: rtl/alu_pipe_pkg.sv
// Shared types and Hack ALU op encodings for the pipelined ALU (package alu_pkg).
package alu_pkg;

   typedef struct packed {
      logic zx;
      logic nx;
      logic zy;
      logic ny;
      logic f;
      logic no;
   } alu_ctrl_t;

   localparam logic [5:0] ALU_OP_ZERO    = 6'b101010;
   localparam logic [5:0] ALU_OP_ONE     = 6'b111111;
   localparam logic [5:0] ALU_OP_NEG1    = 6'b111010;
   localparam logic [5:0] ALU_OP_X       = 6'b001100;
   localparam logic [5:0] ALU_OP_Y       = 6'b110000;
   localparam logic [5:0] ALU_OP_NOTX    = 6'b001101;
   localparam logic [5:0] ALU_OP_XPLUSY  = 6'b000010;
   localparam logic [5:0] ALU_OP_XMINUSY = 6'b010011;
   localparam logic [5:0] ALU_OP_XANDY   = 6'b000000;
   localparam logic [5:0] ALU_OP_XORY    = 6'b010101;

endpackage

// File: rtl/alu_pipe_slice.sv
// Single valid/ready register slice; holds its beat until the downstream side accepts it.
module alu_pipe_slice
   import alu_pkg::*;
#(
   parameter int unsigned DW = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [DW-1:0] in_data,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] out_data
);

   logic          vld;
   logic [DW-1:0] data;

   assign in_ready  = !vld || out_ready;
   assign out_valid = vld;
   assign out_data  = data;

   // Data only captures real beats so the held value never changes on a bubble.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         vld  <= 1'b0;
         data <= '0;
      end else if (in_ready) begin
         vld <= in_valid;
         if (in_valid) data <= in_data;
      end
   end

endmodule

// File: rtl/alu_pipe.sv
// Two-stage pipelined Hack ALU with valid/ready on both sides.
// Define ALU_PIPE_FLAGS_EN to add the carry/ovf adder flag outputs.
module alu_pipe
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   input  logic [5:0]       ctrl,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out,
   output logic             zr,
   output logic             ng
`ifdef ALU_PIPE_FLAGS_EN
  ,output logic             carry
  ,output logic             ovf
`endif
);

   localparam int unsigned S1W = 2 * WIDTH + 2;
`ifdef ALU_PIPE_FLAGS_EN
   localparam int unsigned S2W = WIDTH + 4;
`else
   localparam int unsigned S2W = WIDTH + 2;
`endif

   alu_ctrl_t        c;
   logic [WIDTH-1:0] xz, yz, x2, y2;
   logic [S1W-1:0]   s1_in, s1_q;
   logic             s1_vld, s2_rdy;
   logic [WIDTH-1:0] sx, sy, sum, fout, res;
   logic             sf, sno;
   logic [S2W-1:0]   s2_in, s2_q;

   assign c  = alu_ctrl_t'(ctrl);
   assign xz = c.zx ? '0 : x;
   assign x2 = c.nx ? ~xz : xz;
   assign yz = c.zy ? '0 : y;
   assign y2 = c.ny ? ~yz : yz;
   assign s1_in = {x2, y2, c.f, c.no};

   alu_pipe_slice #(.DW(S1W)) u_s1 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (s1_in),
      .out_valid (s1_vld),
      .out_ready (s2_rdy),
      .out_data  (s1_q)
   );

   assign {sx, sy, sf, sno} = s1_q;

`ifdef ALU_PIPE_FLAGS_EN
   logic [WIDTH:0] sum_ext;
   logic           carry_d, ovf_d;
   assign sum_ext = {1'b0, sx} + {1'b0, sy};
   assign sum     = sum_ext[WIDTH-1:0];
   assign carry_d = sf && sum_ext[WIDTH];
   assign ovf_d   = sf && (sx[WIDTH-1] == sy[WIDTH-1]) && (sum[WIDTH-1] != sx[WIDTH-1]);
`else
   assign sum = sx + sy;
`endif

   assign fout = sf ? sum : (sx & sy);
   assign res  = sno ? ~fout : fout;

   // zr/ng travel with res so reset can force them to 0 independent of res.
`ifdef ALU_PIPE_FLAGS_EN
   assign s2_in = {res, ~|res, res[WIDTH-1], carry_d, ovf_d};
`else
   assign s2_in = {res, ~|res, res[WIDTH-1]};
`endif

   alu_pipe_slice #(.DW(S2W)) u_s2 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (s1_vld),
      .in_ready  (s2_rdy),
      .in_data   (s2_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (s2_q)
   );

`ifdef ALU_PIPE_FLAGS_EN
   assign {out, zr, ng, carry, ovf} = s2_q;
`else
   assign {out, zr, ng} = s2_q;
`endif

endmodule

// File: tb/tb_alu_pipe.sv
// Directed self-checking bench for alu_pipe at WIDTH=16 and WIDTH=8.
// carry/ovf checks compile in only when ALU_PIPE_FLAGS_EN is defined.
module tb_alu_pipe;
   import alu_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid, in_ready, out_valid, out_ready, zr, ng;
   logic [15:0] x, y, out;
   logic [5:0]  ctrl;
`ifdef ALU_PIPE_FLAGS_EN
   logic        carry, ovf;
`endif
   logic        in_valid8, in_ready8, out_valid8, out_ready8, zr8, ng8;
   logic [7:0]  x8, y8, out8;
   logic [5:0]  ctrl8;
`ifdef ALU_PIPE_FLAGS_EN
   logic        carry8, ovf8;
`endif

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   alu_pipe #(.WIDTH(16)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .x(x), .y(y), .ctrl(ctrl), .out_valid(out_valid), .out_ready(out_ready),
      .out(out), .zr(zr), .ng(ng)
`ifdef ALU_PIPE_FLAGS_EN
     ,.carry(carry), .ovf(ovf)
`endif
   );

   alu_pipe #(.WIDTH(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
      .x(x8), .y(y8), .ctrl(ctrl8), .out_valid(out_valid8), .out_ready(out_ready8),
      .out(out8), .zr(zr8), .ng(ng8)
`ifdef ALU_PIPE_FLAGS_EN
     ,.carry(carry8), .ovf(ovf8)
`endif
   );

   // Drives one beat with out_ready high and samples the result 2 cycles after accept.
   task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic [5:0] op,
                         output logic [15:0] r, output logic z, output logic n, output logic lat_ok);
      out_ready = 1'b1; x = a; y = b; ctrl = op; in_valid = 1'b1;
      #1;
      lat_ok = in_ready;
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat_ok = lat_ok && !out_valid;
      @(posedge clk); #1;
      lat_ok = lat_ok && out_valid;
      r = out; z = zr; n = ng;
   endtask

   task automatic run_op8(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op,
                          output logic [7:0] r, output logic z, output logic n, output logic lat_ok);
      out_ready8 = 1'b1; x8 = a; y8 = b; ctrl8 = op; in_valid8 = 1'b1;
      #1;
      lat_ok = in_ready8;
      @(posedge clk); #1;
      in_valid8 = 1'b0;
      lat_ok = lat_ok && !out_valid8;
      @(posedge clk); #1;
      lat_ok = lat_ok && out_valid8;
      r = out8; z = zr8; n = ng8;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      in_valid = 1'b0; x = '0; y = '0; ctrl = '0; out_ready = 1'b1;
      in_valid8 = 1'b0; x8 = '0; y8 = '0; ctrl8 = '0; out_ready8 = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      checks++;
      if ({out_valid, in_ready, out, zr, ng} !== {1'b0, 1'b1, 16'h0000, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL reset_state got v=%b rdy=%b out=%h zr=%b ng=%b exp v=0 rdy=1 out=0000 zr=0 ng=0",
                  out_valid, in_ready, out, zr, ng);
      end
      checks++;
      if ({out_valid8, in_ready8, out8, zr8, ng8} !== {1'b0, 1'b1, 8'h00, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL reset_state8 got v=%b rdy=%b out=%h exp v=0 rdy=1 out=00", out_valid8, in_ready8, out8);
      end
   endtask

   task automatic test_basic_ops;
      logic [15:0] r;
      logic z, n, ok;
      run_op(16'd5, 16'd3, ALU_OP_XPLUSY, r, z, n, ok);
      checks++;
      if ({ok, r, z, n} !== {1'b1, 16'd8, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL add_5_3 got lat_ok=%b out=%h zr=%b ng=%b exp lat_ok=1 out=0008 zr=0 ng=0", ok, r, z, n);
      end
      run_op(16'd3, 16'd5, ALU_OP_XMINUSY, r, z, n, ok);
      checks++;
      if ({ok, r, z, n} !== {1'b1, 16'hFFFE, 1'b0, 1'b1}) begin
         errors++;
         $display("FAIL sub_3_5 got out=%h zr=%b ng=%b exp out=fffe zr=0 ng=1", r, z, n);
      end
      run_op(16'd7, 16'd7, ALU_OP_XMINUSY, r, z, n, ok);
      checks++;
      if ({ok, r, z, n} !== {1'b1, 16'h0000, 1'b1, 1'b0}) begin
         errors++;
         $display("FAIL sub_7_7 got out=%h zr=%b ng=%b exp out=0000 zr=1 ng=0", r, z, n);
      end
      run_op(16'h1234, 16'h00FF, ALU_OP_XANDY, r, z, n, ok);
      checks++;
      if ({ok, r} !== {1'b1, 16'h0034}) begin
         errors++;
         $display("FAIL and got out=%h exp 0034", r);
      end
      run_op(16'h1234, 16'h5678, ALU_OP_NOTX, r, z, n, ok);
      checks++;
      if ({ok, r, n} !== {1'b1, 16'hEDCB, 1'b1}) begin
         errors++;
         $display("FAIL notx got out=%h ng=%b exp edcb ng=1", r, n);
      end
      run_op(16'h1234, 16'h5678, ALU_OP_Y, r, z, n, ok);
      checks++;
      if ({ok, r} !== {1'b1, 16'h5678}) begin
         errors++;
         $display("FAIL pass_y got out=%h exp 5678", r);
      end
      run_op(16'h1234, 16'h5678, ALU_OP_ZERO, r, z, n, ok);
      checks++;
      if ({ok, r, z} !== {1'b1, 16'h0000, 1'b1}) begin
         errors++;
         $display("FAIL zero got out=%h zr=%b exp 0000 zr=1", r, z);
      end
   endtask

   task automatic test_flags;
      logic [15:0] r;
      logic z, n, ok;
      run_op(16'h7FFF, 16'h0001, ALU_OP_XPLUSY, r, z, n, ok);
      checks++;
      if ({ok, r, n} !== {1'b1, 16'h8000, 1'b1}) begin
         errors++;
         $display("FAIL add_7fff_1 got out=%h ng=%b exp 8000 ng=1", r, n);
      end
`ifdef ALU_PIPE_FLAGS_EN
      checks++;
      if ({ovf, carry} !== 2'b10) begin
         errors++;
         $display("FAIL flags_7fff_1 got ovf=%b carry=%b exp ovf=1 carry=0", ovf, carry);
      end
`endif
      run_op(16'hFFFF, 16'h0001, ALU_OP_XPLUSY, r, z, n, ok);
      checks++;
      if ({ok, r, z} !== {1'b1, 16'h0000, 1'b1}) begin
         errors++;
         $display("FAIL add_ffff_1 got out=%h zr=%b exp 0000 zr=1", r, z);
      end
`ifdef ALU_PIPE_FLAGS_EN
      checks++;
      if ({ovf, carry} !== 2'b01) begin
         errors++;
         $display("FAIL flags_ffff_1 got ovf=%b carry=%b exp ovf=0 carry=1", ovf, carry);
      end
      run_op(16'hFFFF, 16'h0001, ALU_OP_XANDY, r, z, n, ok);
      checks++;
      if ({ovf, carry} !== 2'b00) begin
         errors++;
         $display("FAIL flags_and got ovf=%b carry=%b exp 0 0", ovf, carry);
      end
`endif
   endtask

   task automatic test_width8;
      logic [7:0] r;
      logic z, n, ok;
      run_op8(8'h12, 8'h34, ALU_OP_NEG1, r, z, n, ok);
      checks++;
      if ({ok, r, n} !== {1'b1, 8'hFF, 1'b1}) begin
         errors++;
         $display("FAIL w8_neg1 got out=%h ng=%b exp ff ng=1", r, n);
      end
      run_op8(8'h12, 8'h34, ALU_OP_ONE, r, z, n, ok);
      checks++;
      if ({ok, r, n} !== {1'b1, 8'h01, 1'b0}) begin
         errors++;
         $display("FAIL w8_one got out=%h exp 01", r);
      end
      run_op8(8'hA0, 8'h0A, ALU_OP_XORY, r, z, n, ok);
      checks++;
      if ({ok, r} !== {1'b1, 8'hAA}) begin
         errors++;
         $display("FAIL w8_or got out=%h exp aa", r);
      end
   endtask

   task automatic test_back_to_back;
      int sent = 0;
      int recv = 0;
      int cyc = 0;
      logic        held = 1'b0;
      logic [15:0] held_val = '0;
      logic [15:0] exp_v;
      while (recv < 10 && cyc < 60) begin
         out_ready = !(cyc >= 5 && cyc < 9);
         in_valid  = (sent < 10);
         x = 16'(sent * 3 + 1);
         y = 16'(sent);
         ctrl = ALU_OP_XPLUSY;
         #1;
         if (held) begin
            checks++;
            if (out !== held_val) begin
               errors++;
               $display("FAIL stall_stable cyc=%0d got out=%h exp %h", cyc, out, held_val);
            end
         end
         if (!out_ready) begin
            checks++;
            if (in_ready !== 1'b0) begin
               errors++;
               $display("FAIL full_in_ready cyc=%0d got %b exp 0", cyc, in_ready);
            end
         end
         if (out_valid && out_ready) begin
            exp_v = 16'(recv * 4 + 1);
            checks++;
            if (out !== exp_v) begin
               errors++;
               $display("FAIL b2b_beat%0d got out=%h exp %h", recv, out, exp_v);
            end
            recv++;
         end
         held = out_valid && !out_ready;
         held_val = out;
         if (in_valid && in_ready) sent++;
         @(posedge clk); #1;
         cyc++;
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      checks++;
      if (recv !== 10 || sent !== 10) begin
         errors++;
         $display("FAIL b2b_count got sent=%0d recv=%0d exp 10 10", sent, recv);
      end
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL b2b_no_dup got out_valid=%b exp 0", out_valid);
      end
   endtask

   task automatic test_reset_full;
      int waitc = 0;
      logic [15:0] r;
      logic z, n, ok;
      out_ready = 1'b0;
      in_valid = 1'b1; x = 16'hFFFF; y = 16'h0000; ctrl = ALU_OP_XANDY;
      #1;
      while (in_ready && waitc < 10) begin
         @(posedge clk); #1;
         waitc++;
      end
      in_valid = 1'b0;
      checks++;
      if ({in_ready, out_valid, zr, ng} !== {1'b0, 1'b1, 1'b1, 1'b0}) begin
         errors++;
         $display("FAIL fill_pipe got in_ready=%b out_valid=%b zr=%b ng=%b exp 0 1 1 0",
                  in_ready, out_valid, zr, ng);
      end
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      checks++;
      if ({out_valid, out, zr, ng, in_ready} !== {1'b0, 16'h0000, 1'b0, 1'b0, 1'b1}) begin
         errors++;
         $display("FAIL reset_full got v=%b out=%h zr=%b ng=%b rdy=%b exp v=0 out=0000 zr=0 ng=0 rdy=1",
                  out_valid, out, zr, ng, in_ready);
      end
`ifdef ALU_PIPE_FLAGS_EN
      checks++;
      if ({carry, ovf} !== 2'b00) begin
         errors++;
         $display("FAIL reset_flags got carry=%b ovf=%b exp 0 0", carry, ovf);
      end
`endif
      run_op(16'h0010, 16'h0020, ALU_OP_X, r, z, n, ok);
      checks++;
      if ({ok, r} !== {1'b1, 16'h0010}) begin
         errors++;
         $display("FAIL post_reset_op got lat_ok=%b out=%h exp 1 0010", ok, r);
      end
   endtask

   initial begin
      test_reset;
      test_basic_ops;
      test_flags;
      test_width8;
      test_back_to_back;
      test_reset_full;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
